// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, prescale constants and bit indices for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam logic [3:0] START_BIT     = 4'd0;
    localparam logic [3:0] LAST_DATA_BIT = 4'd8;
    localparam logic [3:0] PAR_BIT       = 4'd9;

    // Anything other than 16 or 32 falls back to the slowest legal ratio.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversample edge counter and frame bit counter
module uart_rx_edge_bit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] prescale,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       wrap
);

    assign wrap = enable && (edge_cnt == prescale - 6'd1);

    // Dropping enable clears both counters so the next frame starts from bit 0, edge 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame sequencer driving sampling, check and deserializer enables
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    rx_state_t  state, next_state;
    logic       cfg_par_en;
    logic [5:0] cfg_prescale;
    logic       frame_err;
    logic [3:0] cnt_bit;
    logic       wrap;
    logic       in_bit;
    logic       chk_edge;

    assign in_bit = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

    uart_rx_edge_bit_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (in_bit),
        .prescale (cfg_prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (cnt_bit),
        .wrap     (wrap)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_in) next_state = START;
            START:   if (wrap) next_state = strt_glitch ? IDLE : DATA;
            DATA:    if (wrap && cnt_bit == LAST_DATA_BIT) next_state = cfg_par_en ? PARITY : STOP;
            PARITY:  if (wrap) next_state = STOP;
            STOP:    if (wrap) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cfg_par_en   <= 1'b0;
            cfg_prescale <= '0;
            frame_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && !rx_in) begin
                cfg_par_en   <= par_en;
                cfg_prescale <= legal_prescale(prescale);
                frame_err    <= 1'b0;
            end else if (state == PARITY && wrap) begin
                frame_err <= frame_err | par_err;
            end else if (state == STOP && wrap) begin
                frame_err <= frame_err | stp_err;
            end
        end
    end

    // The counter briefly holds the post-wrap bit index after leaving a bit state; hide it.
    assign bit_cnt     = in_bit ? cnt_bit : 4'd0;
    assign chk_edge    = (edge_cnt == cfg_prescale - 6'd2);
    assign dat_samp_en = in_bit;
    assign strt_chk_en = (state == START) && chk_edge && (cnt_bit == START_BIT);
    assign deser_en    = (state == DATA) && chk_edge;
    assign par_chk_en  = (state == PARITY) && chk_edge && (cnt_bit == PAR_BIT);
    assign stp_chk_en  = (state == STOP) && chk_edge;
    assign data_valid  = (state == DONE) && !frame_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    logic       clk, rst_n, rx_in, par_en;
    logic [5:0] prescale;
    logic       strt_glitch, par_err, stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

    logic glitch_cfg, perr_cfg, serr_cfg;
    int   tests, fails;

    int        o_deser, o_strt, o_par, o_stp, o_dv, o_dv_c, o_end_c, o_first_deser, o_last_edge, o_last_bit;
    rx_state_t o_state_end, o_state_after;

    uart_rx_fsm dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    // Registered check blocks: flag appears the cycle after its enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_glitch <= 1'b0; par_err <= 1'b0; stp_err <= 1'b0;
        end else begin
            strt_glitch <= strt_chk_en & glitch_cfg;
            par_err     <= par_chk_en & perr_cfg;
            stp_err     <= stp_chk_en & serr_cfg;
        end
    end

    // Call on a negedge with the DUT idle; c=0 is the first sample taken in START.
    task automatic run_frame(input logic [5:0] presc, input int p, input logic par, input logic g,
                             input logic pe, input logic se, input logic [7:0] data, input logic chain);
        int len;
        logic [10:0] bits;
        len = g ? p : p * (10 + int'(par));
        bits = 11'h7FF; bits[0] = 1'b0; bits[8:1] = data;
        if (par) bits[9] = ^data;
        glitch_cfg = g; perr_cfg = pe; serr_cfg = se;
        prescale = presc; par_en = par; rx_in = 1'b0;
        o_deser = 0; o_strt = 0; o_par = 0; o_stp = 0; o_dv = 0; o_dv_c = -1;
        o_end_c = -1; o_first_deser = -1; o_last_edge = -1; o_last_bit = -1;
        o_state_end = IDLE; o_state_after = DONE;
        for (int c = 0; c <= len + 1; c++) begin
            @(negedge clk);
            if (deser_en)    begin o_deser++; if (o_first_deser < 0) o_first_deser = c; end
            if (strt_chk_en) o_strt++;
            if (par_chk_en)  o_par++;
            if (stp_chk_en)  o_stp++;
            if (data_valid)  begin o_dv++; o_dv_c = c; end
            if (o_end_c >= 0 && c == o_end_c + 1) o_state_after = dut.state;
            if (dat_samp_en !== 1'b1 && o_end_c < 0) begin
                o_end_c = c; o_state_end = dut.state;
            end else if (o_end_c < 0) begin
                o_last_edge = int'(edge_cnt); o_last_bit = int'(bit_cnt);
            end
            if (c == 3) begin prescale = presc ^ 6'd24; par_en = ~par; end
            if (g)                  rx_in = (c + 1 < 3) ? 1'b0 : 1'b1;
            else if (c + 1 < len)   rx_in = bits[(c + 1) / p];
            else                    rx_in = chain ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if ({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 16'h0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_parity_frame();
        run_frame(6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        tests++; if (o_deser !== 8)        begin fails++; $display("FAIL par_deser_cnt: got %0d expected 8", o_deser); end
        tests++; if (o_first_deser !== 14) begin fails++; $display("FAIL par_first_deser: got %0d expected 14", o_first_deser); end
        tests++; if (o_dv !== 1)           begin fails++; $display("FAIL par_dv_cnt: got %0d expected 1", o_dv); end
        tests++; if (o_dv_c !== 88)        begin fails++; $display("FAIL par_dv_cycle: got %0d expected 88", o_dv_c); end
        tests++; if (o_strt !== 1 || o_par !== 1 || o_stp !== 1) begin
            fails++; $display("FAIL par_chk_pulses: got strt=%0d par=%0d stp=%0d expected 1 1 1", o_strt, o_par, o_stp); end
        tests++; if (o_last_edge !== 7 || o_last_bit !== 10) begin
            fails++; $display("FAIL par_last_count: got edge=%0d bit=%0d expected 7 10", o_last_edge, o_last_bit); end
        tests++; if (o_state_end !== DONE || o_state_after !== IDLE) begin
            fails++; $display("FAIL par_done_idle: got %0d,%0d expected %0d,%0d", o_state_end, o_state_after, DONE, IDLE); end
    endtask

    task automatic test_parity_error();
        run_frame(6'd8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
        tests++; if (o_par !== 1)   begin fails++; $display("FAIL perr_chk: got %0d expected 1", o_par); end
        tests++; if (o_dv !== 0)    begin fails++; $display("FAIL perr_dv: got %0d expected 0", o_dv); end
        tests++; if (o_end_c !== 88 || o_state_after !== IDLE) begin
            fails++; $display("FAIL perr_idle: got end=%0d state=%0d expected 88 %0d", o_end_c, o_state_after, IDLE); end
    endtask

    task automatic test_start_glitch();
        run_frame(6'd16, 16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++; if (o_end_c !== 16 || o_state_end !== IDLE) begin
            fails++; $display("FAIL glitch_idle: got end=%0d state=%0d expected 16 %0d", o_end_c, o_state_end, IDLE); end
        tests++; if (o_last_edge !== 15 || o_last_bit !== 0) begin
            fails++; $display("FAIL glitch_last_count: got edge=%0d bit=%0d expected 15 0", o_last_edge, o_last_bit); end
        tests++; if (o_deser !== 0 || o_dv !== 0) begin
            fails++; $display("FAIL glitch_no_data: got deser=%0d dv=%0d expected 0 0", o_deser, o_dv); end
    endtask

    task automatic test_stop_error();
        run_frame(6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        tests++; if (o_end_c !== 80 || o_state_end !== DONE) begin
            fails++; $display("FAIL serr_done: got end=%0d state=%0d expected 80 %0d", o_end_c, o_state_end, DONE); end
        tests++; if (o_dv !== 0 || o_par !== 0) begin fails++; $display("FAIL serr_dv: got dv=%0d par=%0d expected 0 0", o_dv, o_par); end
        tests++; if (o_last_bit !== 9) begin fails++; $display("FAIL serr_stop_bit: got %0d expected 9", o_last_bit); end
        run_frame(6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
        tests++; if (o_dv !== 1 || o_dv_c !== 80) begin
            fails++; $display("FAIL serr_next_frame: got dv=%0d at %0d expected 1 at 80", o_dv, o_dv_c); end
    endtask

    task automatic test_prescale();
        run_frame(6'd32, 32, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0);
        tests++; if (o_dv_c !== 352 || o_last_edge !== 31) begin
            fails++; $display("FAIL p32_frame: got dv_at=%0d edge=%0d expected 352 31", o_dv_c, o_last_edge); end
        tests++; if (o_deser !== 8 || o_first_deser !== 62) begin
            fails++; $display("FAIL p32_deser: got %0d first %0d expected 8 first 62", o_deser, o_first_deser); end
        run_frame(6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
        tests++; if (o_dv_c !== 80 || o_first_deser !== 14) begin
            fails++; $display("FAIL illegal_presc: got dv_at=%0d first_deser=%0d expected 80 14", o_dv_c, o_first_deser); end
    endtask

    task automatic test_back_to_back();
        int total_dv;
        run_frame(6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
        total_dv = o_dv;
        tests++; if (o_dv_c !== 88) begin fails++; $display("FAIL b2b_first: got %0d expected 88", o_dv_c); end
        run_frame(6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1);
        total_dv += o_dv;
        tests++; if (o_end_c !== 88 || o_dv !== 0) begin
            fails++; $display("FAIL b2b_err_frame: got end=%0d dv=%0d expected 88 0", o_end_c, o_dv); end
        run_frame(6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0);
        total_dv += o_dv;
        tests++; if (o_dv_c !== 88 || total_dv !== 2) begin
            fails++; $display("FAIL b2b_clear: got dv_at=%0d total=%0d expected 88 2", o_dv_c, total_dv); end
    endtask

    task automatic test_reset_midframe();
        int waited, dv_seen, busy_seen;
        glitch_cfg = 0; perr_cfg = 0; serr_cfg = 0;
        prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
        waited = 0;
        @(negedge clk); rx_in = 1'b1;
        while (bit_cnt !== 4'd4 && waited < 200) begin @(negedge clk); waited++; end
        tests++; if (waited >= 200) begin fails++; $display("FAIL midrst_reach_bit4: got timeout expected bit_cnt 4"); end
        rst_n = 1'b0;
        #1;
        tests++; if ({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 16'h0
                     || dut.state !== IDLE) begin
            fails++; $display("FAIL midrst_async: got %h state %0d expected 0 state %0d",
                              {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}, dut.state, IDLE); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        dv_seen = 0; busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
            if (dat_samp_en) busy_seen++;
        end
        tests++; if (dv_seen !== 0 || busy_seen !== 0) begin
            fails++; $display("FAIL midrst_quiet: got dv=%0d busy=%0d expected 0 0", dv_seen, busy_seen); end
        run_frame(6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
        tests++; if (o_dv !== 1 || o_dv_c !== 80) begin
            fails++; $display("FAIL midrst_next_frame: got dv=%0d at %0d expected 1 at 80", o_dv, o_dv_c); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        glitch_cfg = 1'b0; perr_cfg = 1'b0; serr_cfg = 1'b0;
        tests = 0; fails = 0;
        test_reset();
        test_parity_frame();
        test_parity_error();
        test_start_glitch();
        test_stop_error();
        test_prescale();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
